alu_arbiter: RTL and testbench

//  Shares the single 32-bit ALU between two requesters (0: main datapath, 1: aux unit).

---
 rtl/alu_arbiter_if.sv | 29 ++
 rtl/alu_arbiter.sv | 113 +++++++++++
 tb/tb_alu_arbiter.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/alu_arbiter_if.sv
// Requester-side bus of the shared-ALU arbiter: two request ports in, one-hot response out.
interface alu_arbiter_if #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned OP_W  = 3
);
    logic [1:0]       req_valid;
    logic [1:0]       req_ready;
    logic [OP_W-1:0]  req_op0;
    logic [WIDTH-1:0] req_a0;
    logic [WIDTH-1:0] req_b0;
    logic [OP_W-1:0]  req_op1;
    logic [WIDTH-1:0] req_a1;
    logic [WIDTH-1:0] req_b1;
    logic [1:0]       rsp_valid;
    logic [1:0]       rsp_ready;
    logic [WIDTH-1:0] rsp_y;
    logic             rsp_zero;
    logic             rsp_err;

    modport master (
        output req_valid, req_op0, req_a0, req_b0, req_op1, req_a1, req_b1, rsp_ready,
        input  req_ready, rsp_valid, rsp_y, rsp_zero, rsp_err
    );

    modport slave (
        input  req_valid, req_op0, req_a0, req_b0, req_op1, req_a1, req_b1, rsp_ready,
        output req_ready, rsp_valid, rsp_y, rsp_zero, rsp_err
    );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin sharing of one ALU between two requesters; operands registered into the
// ALU, result captured one cycle later and held until the owner accepts it.
module alu_arbiter #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned OP_W  = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    alu_arbiter_if.slave     bus,
    output logic [OP_W-1:0]  alu_ctrl,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    input  logic [WIDTH-1:0] alu_y,
    input  logic             alu_zero,
    output logic             busy,
    output logic             grant_id
);
    localparam logic [OP_W-1:0] ALU_AND = OP_W'(3'b000);
    localparam logic [OP_W-1:0] ALU_OR  = OP_W'(3'b001);
    localparam logic [OP_W-1:0] ALU_ADD = OP_W'(3'b010);
    localparam logic [OP_W-1:0] ALU_OFF = OP_W'(3'b011);
    localparam logic [OP_W-1:0] ALU_SUB = OP_W'(3'b110);
    localparam logic [OP_W-1:0] ALU_SLT = OP_W'(3'b111);

    typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

    state_t           state, state_nxt;
    logic             ptr;
    logic             win;
    logic             any_valid;
    logic             op_ok;
    logic [OP_W-1:0]  op_q;
    logic [WIDTH-1:0] a_q, b_q;

    assign any_valid = |bus.req_valid;
    // With both requesters valid the round-robin pointer decides.
    assign win       = (bus.req_valid == 2'b11) ? ptr : bus.req_valid[1];
    assign op_ok     = (op_q == ALU_AND) || (op_q == ALU_OR) || (op_q == ALU_ADD) ||
                       (op_q == ALU_SUB) || (op_q == ALU_SLT);

    assign alu_a = a_q;
    assign alu_b = b_q;
    assign busy  = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt     = state;
        bus.req_ready = '0;
        bus.rsp_valid = '0;
        alu_ctrl      = ALU_OFF;
        case (state)
            IDLE: begin
                if (any_valid) begin
                    bus.req_ready = win ? 2'b10 : 2'b01;
                    state_nxt     = ISSUE;
                end
            end
            ISSUE: begin
                if (op_ok) alu_ctrl = op_q;
                state_nxt = RESP;
            end
            RESP: begin
                bus.rsp_valid = grant_id ? 2'b10 : 2'b01;
                if (bus.rsp_ready[grant_id]) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr          <= 1'b0;
            grant_id     <= 1'b0;
            op_q         <= ALU_OFF;
            a_q          <= '0;
            b_q          <= '0;
            bus.rsp_y    <= '0;
            bus.rsp_zero <= 1'b0;
            bus.rsp_err  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_valid) begin
                        grant_id <= win;
                        op_q     <= win ? bus.req_op1 : bus.req_op0;
                        a_q      <= win ? bus.req_a1  : bus.req_a0;
                        b_q      <= win ? bus.req_b1  : bus.req_b0;
                    end
                end
                ISSUE: begin
                    // Invalid ops never drive the ALU, so its floating output is discarded.
                    if (op_ok) begin
                        bus.rsp_y    <= alu_y;
                        bus.rsp_zero <= alu_zero;
                        bus.rsp_err  <= 1'b0;
                    end else begin
                        bus.rsp_y    <= '0;
                        bus.rsp_zero <= 1'b1;
                        bus.rsp_err  <= 1'b1;
                    end
                end
                RESP: begin
                    if (bus.rsp_ready[grant_id]) ptr <= ~grant_id;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed vector table, reset/backpressure
// sequences and randomized transactions against a behavioural arbitration model.
module tb_alu_arbiter;
    localparam logic [2:0] AND_OP = 3'b000;
    localparam logic [2:0] OR_OP  = 3'b001;
    localparam logic [2:0] ADD_OP = 3'b010;
    localparam logic [2:0] OFF_OP = 3'b011;
    localparam logic [2:0] SUB_OP = 3'b110;
    localparam logic [2:0] SLT_OP = 3'b111;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [2:0]  alu_ctrl;
    logic [31:0] alu_a, alu_b, alu_y;
    logic        alu_zero, busy, grant_id;

    int unsigned checks = 0;
    int unsigned errors = 0;
    logic        m_ptr  = 1'b0;

    alu_arbiter_if #(.WIDTH(32), .OP_W(3)) bus ();

    alu_arbiter #(.WIDTH(32), .OP_W(3)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus),
        .alu_ctrl (alu_ctrl),
        .alu_a    (alu_a),
        .alu_b    (alu_b),
        .alu_y    (alu_y),
        .alu_zero (alu_zero),
        .busy     (busy),
        .grant_id (grant_id)
    );

    always #5 clk = ~clk;

    function automatic logic op_valid(input logic [2:0] op);
        return (op == AND_OP) || (op == OR_OP) || (op == ADD_OP) ||
               (op == SUB_OP) || (op == SLT_OP);
    endfunction

    function automatic logic [31:0] op_result(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            AND_OP:  return a & b;
            OR_OP:   return a | b;
            ADD_OP:  return a + b;
            SUB_OP:  return a - b;
            SLT_OP:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    // ALU stub: unused/OFF codes produce garbage, which the arbiter must not capture.
    always_comb begin
        if (op_valid(alu_ctrl)) begin
            alu_y    = op_result(alu_ctrl, alu_a, alu_b);
            alu_zero = (alu_y == 32'd0);
        end else begin
            alu_y    = 32'hDEAD_BEEF;
            alu_zero = 1'b0;
        end
    end

    function automatic logic [1:0] onehot(input logic w);
        return w ? 2'b10 : 2'b01;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // One full transaction; the expected owner/result come from the caller.
    task automatic txn(input logic [1:0] vld,
                       input logic [2:0] op0, input logic [31:0] a0, input logic [31:0] b0,
                       input logic [2:0] op1, input logic [31:0] a1, input logic [31:0] b1,
                       input int unsigned bp, input logic ew,
                       input logic [31:0] ey, input logic ez, input logic ee);
        logic [2:0]  wop;
        logic [31:0] wa, wb;
        wop = ew ? op1 : op0;
        wa  = ew ? a1  : a0;
        wb  = ew ? b1  : b0;
        bus.req_valid = vld;
        bus.req_op0 = op0; bus.req_a0 = a0; bus.req_b0 = b0;
        bus.req_op1 = op1; bus.req_a1 = a1; bus.req_b1 = b1;
        bus.rsp_ready = 2'b00;
        #2;
        chk("idle_req_ready", bus.req_ready, onehot(ew));
        chk("idle_alu_ctrl", alu_ctrl, OFF_OP);
        chk("idle_busy", busy, 0);
        step();
        bus.req_valid = bus.req_valid & ~onehot(ew);
        #2;
        chk("issue_req_ready", bus.req_ready, 0);
        chk("issue_busy", busy, 1);
        chk("issue_grant", grant_id, ew);
        chk("issue_alu_ctrl", alu_ctrl, op_valid(wop) ? wop : OFF_OP);
        if (op_valid(wop)) begin
            chk("issue_alu_a", alu_a, wa);
            chk("issue_alu_b", alu_b, wb);
        end
        step();
        #2;
        chk("rsp_valid", bus.rsp_valid, onehot(ew));
        chk("rsp_y", bus.rsp_y, ey);
        chk("rsp_zero", bus.rsp_zero, ez);
        chk("rsp_err", bus.rsp_err, ee);
        chk("rsp_alu_ctrl", alu_ctrl, OFF_OP);
        chk("rsp_req_ready", bus.req_ready, 0);
        for (int unsigned k = 0; k < bp; k++) begin
            bus.rsp_ready = onehot(~ew);
            step();
            #2;
            chk("bp_rsp_valid", bus.rsp_valid, onehot(ew));
            chk("bp_rsp_y", bus.rsp_y, ey);
            chk("bp_req_ready", bus.req_ready, 0);
        end
        bus.rsp_ready = onehot(ew);
        step();
        bus.rsp_ready = 2'b00;
        #2;
        chk("done_rsp_valid", bus.rsp_valid, 0);
        chk("done_busy", busy, 0);
        m_ptr = ~ew;
    endtask

    typedef struct {
        logic [1:0]  vld;
        logic [2:0]  op0; logic [31:0] a0; logic [31:0] b0;
        logic [2:0]  op1; logic [31:0] a1; logic [31:0] b1;
        int unsigned bp;
        logic        ew;
        logic [31:0] ey;
        logic        ez;
        logic        ee;
    } vec_t;

    vec_t tbl[$];

    initial begin
        logic [1:0]  vld;
        logic [2:0]  op0, op1, wop;
        logic [31:0] a0, b0, a1, b1, wa, wb, ey;
        logic        ew;

        bus.req_valid = '0; bus.rsp_ready = '0;
        bus.req_op0 = OFF_OP; bus.req_a0 = '0; bus.req_b0 = '0;
        bus.req_op1 = OFF_OP; bus.req_a1 = '0; bus.req_b1 = '0;
        rst_n = 1'b0;
        #7;
        chk("reset_rsp_valid", bus.rsp_valid, 0);
        chk("reset_req_ready", bus.req_ready, 0);
        chk("reset_rsp_y", bus.rsp_y, 0);
        chk("reset_alu_ctrl", alu_ctrl, OFF_OP);
        chk("reset_busy", busy, 0);
        chk("reset_grant", grant_id, 0);
        rst_n = 1'b1;
        step();

        tbl.push_back('{2'b11, SUB_OP, 32'd41, 32'd41, OR_OP, 32'd8, 32'd41, 0, 1'b0, 32'd0, 1'b1, 1'b0});
        tbl.push_back('{2'b11, SUB_OP, 32'd41, 32'd41, OR_OP, 32'd8, 32'd41, 0, 1'b1, 32'd41, 1'b0, 1'b0});
        tbl.push_back('{2'b01, ADD_OP, 32'd8, 32'd41, OFF_OP, 32'd0, 32'd0, 0, 1'b0, 32'd49, 1'b0, 1'b0});
        tbl.push_back('{2'b11, AND_OP, 32'hFFFF0000, 32'h12345678, ADD_OP, 32'd1, 32'd2, 0, 1'b1, 32'd3, 1'b0, 1'b0});
        tbl.push_back('{2'b11, AND_OP, 32'hFFFF0000, 32'h12345678, ADD_OP, 32'd1, 32'd2, 1, 1'b0, 32'h12340000, 1'b0, 1'b0});
        tbl.push_back('{2'b11, AND_OP, 32'hFFFF0000, 32'h12345678, ADD_OP, 32'd1, 32'd2, 0, 1'b1, 32'd3, 1'b0, 1'b0});
        tbl.push_back('{2'b11, AND_OP, 32'hFFFF0000, 32'h12345678, ADD_OP, 32'd1, 32'd2, 0, 1'b0, 32'h12340000, 1'b0, 1'b0});
        tbl.push_back('{2'b10, OFF_OP, 32'd0, 32'd0, SLT_OP, 32'hFFFFFFFD, 32'hFFFFFFFB, 0, 1'b1, 32'd0, 1'b1, 1'b0});
        tbl.push_back('{2'b01, SLT_OP, 32'hFFFFFFFB, 32'hFFFFFFFD, OFF_OP, 32'd0, 32'd0, 0, 1'b0, 32'd1, 1'b0, 1'b0});
        tbl.push_back('{2'b10, AND_OP, 32'd0, 32'd0, OFF_OP, 32'd7, 32'd9, 0, 1'b1, 32'd0, 1'b1, 1'b1});
        tbl.push_back('{2'b01, 3'b100, 32'd5, 32'd6, OFF_OP, 32'd0, 32'd0, 0, 1'b0, 32'd0, 1'b1, 1'b1});
        tbl.push_back('{2'b10, OFF_OP, 32'd0, 32'd0, SUB_OP, 32'd5, 32'd7, 5, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0});

        foreach (tbl[i])
            txn(tbl[i].vld, tbl[i].op0, tbl[i].a0, tbl[i].b0, tbl[i].op1, tbl[i].a1, tbl[i].b1,
                tbl[i].bp, tbl[i].ew, tbl[i].ey, tbl[i].ez, tbl[i].ee);

        // Leave the pointer at 1, then reset mid-ISSUE: pointer must return to 0.
        txn(2'b01, ADD_OP, 32'd100, 32'd23, OFF_OP, 32'd0, 32'd0, 0, 1'b0, 32'd123, 1'b0, 1'b0);
        bus.req_valid = 2'b10; bus.req_op1 = ADD_OP; bus.req_a1 = 32'd3; bus.req_b1 = 32'd4;
        step();
        bus.req_valid = 2'b00;
        #1;
        chk("pre_reset_busy", busy, 1);
        rst_n = 1'b0;
        #1;
        chk("midrst_rsp_valid", bus.rsp_valid, 0);
        chk("midrst_req_ready", bus.req_ready, 0);
        chk("midrst_rsp_y", bus.rsp_y, 0);
        chk("midrst_rsp_zero", bus.rsp_zero, 0);
        chk("midrst_rsp_err", bus.rsp_err, 0);
        chk("midrst_alu_ctrl", alu_ctrl, OFF_OP);
        chk("midrst_alu_a", alu_a, 0);
        chk("midrst_alu_b", alu_b, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_grant", grant_id, 0);
        #3;
        rst_n = 1'b1;
        m_ptr = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("postrst_rsp_valid", bus.rsp_valid, 0);
            chk("postrst_busy", busy, 0);
        end
        txn(2'b11, ADD_OP, 32'd1, 32'd1, ADD_OP, 32'd2, 32'd2, 0, 1'b0, 32'd2, 1'b0, 1'b0);

        // Randomized traffic against the arbitration/result model.
        for (int n = 0; n < 200; n++) begin
            vld = 2'($urandom_range(1, 3));
            op0 = 3'($urandom_range(0, 7));
            op1 = 3'($urandom_range(0, 7));
            a0  = $urandom; a1 = $urandom;
            b0  = ($urandom_range(0, 3) == 0) ? a0 : $urandom;
            b1  = ($urandom_range(0, 3) == 0) ? a1 : $urandom;
            ew  = (vld == 2'b11) ? m_ptr : vld[1];
            wop = ew ? op1 : op0;
            wa  = ew ? a1 : a0;
            wb  = ew ? b1 : b0;
            ey  = op_result(wop, wa, wb);
            txn(vld, op0, a0, b0, op1, a1, b1, $urandom_range(0, 3), ew,
                ey, (ey == 32'd0), !op_valid(wop));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
